// File: rtl/potential_decay_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : potential_decay_pipe_if
//  Description : Stream interface for the LIF potential decay pipeline.
//                The input side carries {neuron address, fp32 potential} with
//                a valid/ready handshake. The output side returns the
//                decayed potential, the same address tag and a flush flag.
//                master : the producer/consumer environment around the unit
//                slave  : the decay unit itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface potential_decay_pipe_if #(
    parameter int ADDR_W = 12
) ();

    // Input stream (potential adder -> decay unit)
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_potential;

    // Output stream (decay unit -> membrane-potential store)
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_potential;
    logic              out_flush;

    modport master (
        output in_valid,
        output in_addr,
        output in_potential,
        input  in_ready,
        input  out_valid,
        input  out_addr,
        input  out_potential,
        input  out_flush,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_addr,
        input  in_potential,
        output in_ready,
        output out_valid,
        output out_addr,
        output out_potential,
        output out_flush,
        input  out_ready
    );

endinterface

`default_nettype wire

// File: rtl/potential_decay_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : potential_decay_pipe
//  Description : Pipelined multi-neuron LIF leak unit for fp32 membrane
//                potentials. Each accepted {address, potential} is decayed by
//                the rate code stored for that neuron in an internal table
//                and returned two cycles later with the same address tag.
//
//  Ports
//    CLK_Decay    in   clock, rising edge
//    RESETn_Decay in   asynchronous active-low reset
//    cfg_we       in   rate-table write strobe
//    cfg_addr     in   rate-table write address (>= NEURONS ignored)
//    cfg_rate     in   rate code to write
//    bus          if   slave side of the in/out stream interface
//    flush_cnt    out  saturating count of delivered flushed results
//
//  Pipeline
//    S1 : input register + rate-table lookup
//    S2 : decay arithmetic into the output register
//    Both stages advance independently, giving full throughput with a
//    skid-free backpressure chain: s2_adv = ~out_valid | out_ready,
//    in_ready = ~s1_valid | s2_adv.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module potential_decay_pipe #(
    parameter int          NEURONS      = 16,
    parameter int          ADDR_W       = 12,
    parameter logic [3:0]  DEFAULT_RATE = 4'b0001
) (
    input  wire logic              CLK_Decay,
    input  wire logic              RESETn_Decay,
    input  wire logic              cfg_we,
    input  wire logic [ADDR_W-1:0] cfg_addr,
    input  wire logic [3:0]        cfg_rate,
    potential_decay_pipe_if.slave  bus,
    output logic [15:0]            flush_cnt
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int              c_IDX_W    = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam logic [ADDR_W:0] c_NEURONS  = (ADDR_W+1)'(NEURONS);

    localparam logic [3:0] c_RATE_ZERO  = 4'b0000;
    localparam logic [3:0] c_RATE_X1    = 4'b0001;
    localparam logic [3:0] c_RATE_DIV2  = 4'b0010;
    localparam logic [3:0] c_RATE_X075  = 4'b0011;
    localparam logic [3:0] c_RATE_DIV4  = 4'b0100;
    localparam logic [3:0] c_RATE_X0875 = 4'b0111;
    localparam logic [3:0] c_RATE_DIV8  = 4'b1000;

    // ------------------------------------------------------------------
    // Rate table
    // ------------------------------------------------------------------
    logic [NEURONS-1:0]      w_cfg_sel;
    logic [NEURONS-1:0][3:0] w_rate_tab;
    logic                    w_cfg_in_range;

    assign w_cfg_in_range = ({1'b0, cfg_addr} < c_NEURONS);

    // One-hot write select; out-of-range addresses select nothing.
    always_comb begin
        w_cfg_sel = '0;
        if (cfg_we && w_cfg_in_range) begin
            w_cfg_sel[cfg_addr[c_IDX_W-1:0]] = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NEURONS; gi++) begin : g_rate_table
            logic [3:0] r_entry;

            always_ff @(posedge CLK_Decay or negedge RESETn_Decay) begin
                if (!RESETn_Decay) begin
                    r_entry <= DEFAULT_RATE;
                end else if (w_cfg_sel[gi]) begin
                    r_entry <= cfg_rate;
                end
            end

            assign w_rate_tab[gi] = r_entry;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake / advance control
    // ------------------------------------------------------------------
    logic              r_s1_valid;
    logic [ADDR_W-1:0] r_s1_addr;
    logic [31:0]       r_s1_pot;
    logic [3:0]        r_s1_rate;

    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic [31:0]       r_out_pot;
    logic              r_out_flush;
    logic [15:0]       r_flush_cnt;

    logic w_s2_adv;
    logic w_in_ready;
    logic w_accept;
    logic w_in_in_range;
    logic [3:0] w_lookup_rate;

    assign w_s2_adv   = ~r_out_valid | bus.out_ready;
    assign w_in_ready = ~r_s1_valid | w_s2_adv;
    assign w_accept   = bus.in_valid & w_in_ready;

    // Out-of-range neurons fall back to unity gain rather than aliasing
    // onto a table entry.
    assign w_in_in_range = ({1'b0, bus.in_addr} < c_NEURONS);
    assign w_lookup_rate = w_in_in_range ? w_rate_tab[bus.in_addr[c_IDX_W-1:0]]
                                         : c_RATE_X1;

    // ------------------------------------------------------------------
    // S1: input register and lookup. The lookup reads the table before
    // the same-edge write lands, so a colliding write is seen by the
    // next accept only.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_Decay or negedge RESETn_Decay) begin
        if (!RESETn_Decay) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_pot   <= '0;
            r_s1_rate  <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_addr  <= bus.in_addr;
            r_s1_pot   <= bus.in_potential;
            r_s1_rate  <= w_lookup_rate;
        end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // S2 arithmetic
    // ------------------------------------------------------------------
    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_frac;
    logic [23:0] w_mant;
    logic [23:0] w_mant_sub;
    logic [23:0] w_mant_norm;

    logic [31:0] w_res;
    logic        w_flush;
    logic        w_scale;
    logic [7:0]  w_dec;
    logic [22:0] w_frac_new;

    assign w_sign = r_s1_pot[31];
    assign w_exp  = r_s1_pot[30:23];
    assign w_frac = r_s1_pot[22:0];
    assign w_mant = {1'b1, w_frac};

    // Fractional gains: subtract a truncated shifted copy of the
    // mantissa. The result is always >= 0.75 of the input, so at most one
    // left shift restores the hidden bit; the bit shifted in is zero.
    assign w_mant_sub  = (r_s1_rate == c_RATE_X0875) ? (w_mant - (w_mant >> 3))
                                                     : (w_mant - (w_mant >> 2));
    assign w_mant_norm = w_mant_sub[23] ? w_mant_sub : {w_mant_sub[22:0], 1'b0};

    always_comb begin
        w_res      = r_s1_pot;
        w_flush    = 1'b0;
        w_scale    = 1'b0;
        w_dec      = 8'd0;
        w_frac_new = w_frac;

        if (w_exp == 8'd0) begin
            // Zero and denormal inputs collapse to signed zero.
            w_res = {w_sign, 31'd0};
        end else if (w_exp != 8'hFF) begin
            case (r_s1_rate)
                c_RATE_ZERO: w_res = {w_sign, 31'd0};
                c_RATE_DIV2: begin
                    w_scale = 1'b1;
                    w_dec   = 8'd1;
                end
                c_RATE_DIV4: begin
                    w_scale = 1'b1;
                    w_dec   = 8'd2;
                end
                c_RATE_DIV8: begin
                    w_scale = 1'b1;
                    w_dec   = 8'd3;
                end
                c_RATE_X075, c_RATE_X0875: begin
                    w_scale    = 1'b1;
                    w_dec      = {7'd0, ~w_mant_sub[23]};
                    w_frac_new = w_mant_norm[22:0];
                end
                default: ;  // unity gain: pass through
            endcase

            // Result exponent <= 0 underflows to signed zero and is
            // reported through out_flush.
            if (w_scale) begin
                if (w_exp <= w_dec) begin
                    w_res   = {w_sign, 31'd0};
                    w_flush = 1'b1;
                end else begin
                    w_res = {w_sign, w_exp - w_dec, w_frac_new};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: output register. Holds stable while stalled.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_Decay or negedge RESETn_Decay) begin
        if (!RESETn_Decay) begin
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_pot   <= '0;
            r_out_flush <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_addr  <= r_s1_addr;
                r_out_pot   <= w_res;
                r_out_flush <= w_flush;
            end
        end
    end

    // Flush counter counts delivered results only, so a stalled result is
    // never counted twice.
    always_ff @(posedge CLK_Decay or negedge RESETn_Decay) begin
        if (!RESETn_Decay) begin
            r_flush_cnt <= 16'd0;
        end else if (r_out_valid && bus.out_ready && r_out_flush &&
                     (r_flush_cnt != 16'hFFFF)) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_addr      = r_out_addr;
    assign bus.out_potential = r_out_pot;
    assign bus.out_flush     = r_out_flush;
    assign flush_cnt         = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_potential_decay_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_potential_decay_pipe
//  Description : Self-checking bench for potential_decay_pipe. Directed
//                vectors plus a randomized back-pressured stream checked
//                against an arithmetic reference model of the decay rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_potential_decay_pipe;

    localparam int c_ADDR_W  = 12;
    localparam int c_NEURONS = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                cfg_we;
    logic [c_ADDR_W-1:0] cfg_addr;
    logic [3:0]          cfg_rate;
    logic [15:0]         flush_cnt;

    int errors = 0;
    int checks = 0;

    logic [3:0] model_rate [c_NEURONS];
    int         model_flush_cnt = 0;

    potential_decay_pipe_if #(.ADDR_W(c_ADDR_W)) bus ();

    potential_decay_pipe #(
        .NEURONS      (c_NEURONS),
        .ADDR_W       (c_ADDR_W),
        .DEFAULT_RATE (4'b0001)
    ) dut (
        .CLK_Decay    (clk),
        .RESETn_Decay (rst_n),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_rate     (cfg_rate),
        .bus          (bus.slave),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: {flush, result} from the arithmetic decay rules.
    // ------------------------------------------------------------------
    function automatic logic [32:0] ref_decay(input logic [31:0] p, input logic [3:0] rate);
        logic       s;
        int         e;
        int         m;
        int         ne;
        int         mm;
        logic [7:0] e8;
        logic [22:0] f23;
        s  = p[31];
        e  = int'(p[30:23]);
        m  = int'({1'b1, p[22:0]});
        if (e == 0)   return {1'b0, s, 31'd0};
        if (e == 255) return {1'b0, p};
        case (rate)
            4'b0000: return {1'b0, s, 31'd0};
            4'b0010: begin ne = e - 1; mm = m; end
            4'b0100: begin ne = e - 2; mm = m; end
            4'b1000: begin ne = e - 3; mm = m; end
            4'b0011: begin ne = e; mm = m - m / 4; end
            4'b0111: begin ne = e; mm = m - m / 8; end
            default: return {1'b0, p};
        endcase
        if (mm < (1 << 23)) begin
            mm = mm * 2;
            ne = ne - 1;
        end
        if (ne <= 0) return {1'b1, s, 31'd0};
        e8  = ne[7:0];
        f23 = mm[22:0];
        return {1'b0, s, e8, f23};
    endfunction

    function automatic logic [3:0] model_lookup(input int a);
        if (a < c_NEURONS) return model_rate[a];
        return 4'b0001;
    endfunction

    function automatic logic [31:0] rand_pot();
        logic [7:0] e;
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0:       e = 8'd0;
            1:       e = 8'd1;
            2:       e = 8'd2;
            3:       e = 8'd3;
            4:       e = 8'hFF;
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // ------------------------------------------------------------------
    // Drive helpers (no checking inside)
    // ------------------------------------------------------------------
    task automatic cfg_write(input int a, input logic [3:0] r);
        @(posedge clk); #1;
        cfg_we   = 1'b1;
        cfg_addr = a[c_ADDR_W-1:0];
        cfg_rate = r;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
        if (a < c_NEURONS) model_rate[a] = r;
    endtask

    // One item through an otherwise idle pipe; returns the result and the
    // number of edges from the accept edge until out_valid is seen.
    task automatic xfer(input int a, input logic [31:0] p,
                        output logic [31:0] res, output logic [c_ADDR_W-1:0] raddr,
                        output logic fl, output int lat);
        int w;
        @(posedge clk); #1;
        bus.in_valid     = 1'b1;
        bus.in_addr      = a[c_ADDR_W-1:0];
        bus.in_potential = p;
        bus.out_ready    = 1'b1;
        @(negedge clk);
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res   = bus.out_potential;
        raddr = bus.out_addr;
        fl    = bus.out_flush;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_addr !== '0)
            begin errors++; $display("FAIL reset_out_addr: got %h expected 0", bus.out_addr); end
        checks++; if (bus.out_potential !== 32'h0)
            begin errors++; $display("FAIL reset_out_potential: got %h expected 0", bus.out_potential); end
        checks++; if (bus.out_flush !== 1'b0)
            begin errors++; $display("FAIL reset_out_flush: got %b expected 0", bus.out_flush); end
        checks++; if (flush_cnt !== 16'd0)
            begin errors++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1)
            begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_shift_rates();
        logic [3:0]          rates [3];
        logic [31:0]         exps  [3];
        logic [31:0]         res;
        logic [c_ADDR_W-1:0] ra;
        logic                fl;
        int                  lat;
        rates = '{4'b0010, 4'b0100, 4'b1000};
        exps  = '{32'h415ED852, 32'h40DED852, 32'h405ED852};
        for (int i = 0; i < 3; i++) begin
            cfg_write(0, rates[i]);
            xfer(0, 32'h41DED852, res, ra, fl, lat);
            checks++; if (lat !== 2)
                begin errors++; $display("FAIL shift_latency[%0d]: got %0d expected 2", i, lat); end
            checks++; if (res !== exps[i] || ra !== '0 || fl !== 1'b0)
                begin errors++; $display("FAIL shift_rate[%0d]: got %h/%h/%b expected %h/0/0", i, res, ra, fl, exps[i]); end
        end
    endtask

    task automatic test_frac_rates();
        logic [31:0]         res;
        logic [c_ADDR_W-1:0] ra;
        logic                fl;
        int                  lat;
        cfg_write(1, 4'b0011);
        xfer(1, 32'h41DED852, res, ra, fl, lat);
        checks++; if (res !== 32'h41A7223E || ra !== 12'd1 || fl !== 1'b0)
            begin errors++; $display("FAIL x075: got %h/%h/%b expected 41a7223e/1/0", res, ra, fl); end
        xfer(1, 32'h3F800000, res, ra, fl, lat);
        checks++; if (res !== 32'h3F400000)
            begin errors++; $display("FAIL x075_norm: got %h expected 3f400000", res); end
        cfg_write(1, 4'b0111);
        xfer(1, 32'h3F800000, res, ra, fl, lat);
        checks++; if (res !== 32'h3F600000)
            begin errors++; $display("FAIL x0875_norm: got %h expected 3f600000", res); end
        xfer(1, 32'hC1DED852, res, ra, fl, lat);
        checks++; if (res !== ref_decay(32'hC1DED852, 4'b0111) && 1'b1)
            begin errors++; $display("FAIL x0875_neg: got %h expected %h", res, ref_decay(32'hC1DED852, 4'b0111)); end
    endtask

    task automatic test_special();
        logic [31:0]         res;
        logic [c_ADDR_W-1:0] ra;
        logic                fl;
        int                  lat;
        cfg_write(2, 4'b0010);
        xfer(2, 32'h00800000, res, ra, fl, lat);
        checks++; if (res !== 32'h0 || fl !== 1'b1)
            begin errors++; $display("FAIL underflow: got %h/%b expected 00000000/1", res, fl); end
        model_flush_cnt++;
        @(posedge clk); @(negedge clk);
        checks++; if (flush_cnt !== 16'(model_flush_cnt))
            begin errors++; $display("FAIL flush_cnt_one: got %0d expected %0d", flush_cnt, model_flush_cnt); end
        xfer(2, 32'hC1DED852, res, ra, fl, lat);
        checks++; if (res !== 32'hC15ED852 || fl !== 1'b0)
            begin errors++; $display("FAIL neg_div2: got %h/%b expected c15ed852/0", res, fl); end
        xfer(2, 32'h80000001, res, ra, fl, lat);
        checks++; if (res !== 32'h80000000 || fl !== 1'b0)
            begin errors++; $display("FAIL denormal: got %h/%b expected 80000000/0", res, fl); end
        cfg_write(2, 4'b1000);
        xfer(2, 32'h7FC00000, res, ra, fl, lat);
        checks++; if (res !== 32'h7FC00000 || fl !== 1'b0)
            begin errors++; $display("FAIL nan_pass: got %h/%b expected 7fc00000/0", res, fl); end
        cfg_write(2, 4'b0000);
        xfer(2, 32'hC0000000, res, ra, fl, lat);
        checks++; if (res !== 32'h80000000 || fl !== 1'b0)
            begin errors++; $display("FAIL rate_zero: got %h/%b expected 80000000/0", res, fl); end
        cfg_write(100, 4'b1000);   // out of range: ignored
        xfer(100, 32'h41DED852, res, ra, fl, lat);
        checks++; if (res !== 32'h41DED852 || ra !== 12'd100)
            begin errors++; $display("FAIL addr_oor: got %h/%h expected 41ded852/064", res, ra); end
    endtask

    task automatic test_back_to_back();
        localparam int N = 24;
        logic [3:0]  codes [8];
        int          addrs [N];
        logic [31:0] pots  [N];
        logic [32:0] q_res [$];
        int          q_adr [$];
        int          sent, got, inflight, cyc;
        logic        exp_rdy;
        logic [32:0] front;
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0111, 4'b1000, 4'b1111};
        for (int i = 0; i < c_NEURONS; i++) cfg_write(i, codes[$urandom_range(0, 7)]);
        cfg_write(20, 4'b0000);
        for (int i = 0; i < N; i++) begin
            addrs[i] = $urandom_range(0, 19);
            pots[i]  = rand_pot();
        end
        sent = 0; got = 0; inflight = 0; cyc = 0;
        while (got < N && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            bus.in_valid = (sent < N);
            if (sent < N) begin
                bus.in_addr      = addrs[sent][c_ADDR_W-1:0];
                bus.in_potential = pots[sent];
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_rdy = !(inflight == 2 && !bus.out_ready);
            checks++; if (bus.in_ready !== exp_rdy)
                begin errors++; $display("FAIL b2b_in_ready cyc %0d: got %b expected %b", cyc, bus.in_ready, exp_rdy); end
            if (bus.out_valid) begin
                checks++;
                if (q_res.size() == 0) begin
                    errors++; $display("FAIL b2b_spurious cyc %0d: got out_valid=1 expected 0", cyc);
                end else begin
                    front = q_res[0];
                    if (bus.out_potential !== front[31:0] || bus.out_flush !== front[32] ||
                        bus.out_addr !== q_adr[0][c_ADDR_W-1:0]) begin
                        errors++;
                        $display("FAIL b2b_data cyc %0d: got %h/%b/%h expected %h/%b/%h", cyc,
                                 bus.out_potential, bus.out_flush, bus.out_addr,
                                 front[31:0], front[32], q_adr[0][c_ADDR_W-1:0]);
                    end
                end
            end
            if (bus.out_valid && bus.out_ready && q_res.size() > 0) begin
                front = q_res.pop_front();
                void'(q_adr.pop_front());
                if (front[32]) model_flush_cnt++;
                got++;
                inflight--;
            end
            if (bus.in_valid && bus.in_ready) begin
                q_res.push_back(ref_decay(pots[sent], model_lookup(addrs[sent])));
                q_adr.push_back(addrs[sent]);
                sent++;
                inflight++;
            end
        end
        checks++; if (got !== N)
            begin errors++; $display("FAIL b2b_timeout: got %0d outputs expected %0d", got, N); end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (flush_cnt !== 16'(model_flush_cnt))
            begin errors++; $display("FAIL b2b_flush_cnt: got %0d expected %0d", flush_cnt, model_flush_cnt); end
    endtask

    task automatic test_cfg_collision();
        logic [31:0] r  [2];
        int          n, w;
        cfg_write(3, 4'b0010);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = 12'd3; cfg_rate = 4'b0100;
        bus.in_valid = 1'b1; bus.in_addr = 12'd3; bus.in_potential = 32'h41DED852;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1)
            begin errors++; $display("FAIL collide_ready: got %b expected 1", bus.in_ready); end
        @(posedge clk); #1;
        cfg_we = 1'b0;
        model_rate[3] = 4'b0100;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0; w = 0;
        r = '{32'h0, 32'h0};
        while (n < 2 && w < 20) begin
            @(negedge clk);
            if (bus.out_valid) begin
                r[n] = bus.out_potential;
                n++;
            end
            w++;
        end
        checks++; if (r[0] !== 32'h415ED852)
            begin errors++; $display("FAIL collide_old_rate: got %h expected 415ed852", r[0]); end
        checks++; if (r[1] !== 32'h40DED852)
            begin errors++; $display("FAIL collide_new_rate: got %h expected 40ded852", r[1]); end
    endtask

    task automatic test_reset_midflight();
        logic [31:0]         res;
        logic [c_ADDR_W-1:0] ra;
        logic                fl;
        int                  lat;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_addr = 12'd0; bus.in_potential = 32'h40000000;
        @(posedge clk); #1;
        bus.in_potential = 32'h40400000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1)
            begin errors++; $display("FAIL midrst_loaded: got %b expected 1", bus.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", bus.out_valid); end
        for (int i = 0; i < c_NEURONS; i++) model_rate[i] = 4'b0001;
        model_flush_cnt = 0;
        checks++; if (flush_cnt !== 16'(model_flush_cnt))
            begin errors++; $display("FAIL midrst_flush_cnt: got %0d expected 0", flush_cnt); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            begin errors++; $display("FAIL midrst_drained: got valid=%b ready=%b expected 0/1", bus.out_valid, bus.in_ready); end
        xfer(0, 32'h41DED852, res, ra, fl, lat);
        checks++; if (res !== ref_decay(32'h41DED852, model_lookup(0)))
            begin errors++; $display("FAIL midrst_default0: got %h expected %h", res, ref_decay(32'h41DED852, model_lookup(0))); end
        xfer(3, 32'hC1DED852, res, ra, fl, lat);
        checks++; if (res !== 32'hC1DED852)
            begin errors++; $display("FAIL midrst_default3: got %h expected c1ded852", res); end
    endtask

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    initial begin
        cfg_we           = 1'b0;
        cfg_addr         = '0;
        cfg_rate         = 4'b0000;
        bus.in_valid     = 1'b0;
        bus.in_addr      = '0;
        bus.in_potential = 32'h0;
        bus.out_ready    = 1'b1;
        for (int i = 0; i < c_NEURONS; i++) model_rate[i] = 4'b0001;

        test_reset();
        test_shift_rates();
        test_frac_rates();
        test_special();
        test_back_to_back();
        test_cfg_collision();
        test_reset_midflight();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
